// File: rtl/clock_pkg.sv
// Shared definitions for the HH-MM-SS clock: mode encoding, field limits and
// blink-mask digit positions.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    localparam int DIG_SEC_L  = 0;
    localparam int DIG_SEC_H  = 1;
    localparam int DIG_MIN_L  = 3;
    localparam int DIG_MIN_H  = 4;
    localparam int DIG_HOUR_L = 6;
    localparam int DIG_HOUR_H = 7;

    // Digits belonging to the field being set; separators are never blanked.
    function automatic logic [7:0] field_mask(input mode_t mode);
        logic [7:0] m;
        m = 8'h00;
        case (mode)
            MODE_SET_HOUR: begin m[DIG_HOUR_H] = 1'b1; m[DIG_HOUR_L] = 1'b1; end
            MODE_SET_MIN:  begin m[DIG_MIN_H]  = 1'b1; m[DIG_MIN_L]  = 1'b1; end
            MODE_SET_SEC:  begin m[DIG_SEC_H]  = 1'b1; m[DIG_SEC_L]  = 1'b1; end
            default:       m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bcd2_mod_counter.sv
// Two-digit BCD up/down counter modulo MAX+1; carry flags an increment
// wrapping MAX -> 0 so it can feed the next field in the same edge.
module bcd2_mod_counter #(
    parameter int MAX = 59
) (
    input  logic       i_clk,
    input  logic       clear,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] o_hi,
    output logic [3:0] o_lo,
    output logic       carry
);

    localparam logic [3:0] MAX_HI = 4'(MAX / 10);
    localparam logic [3:0] MAX_LO = 4'(MAX % 10);

    logic at_max;
    logic at_zero;

    assign at_max  = (o_hi == MAX_HI) && (o_lo == MAX_LO);
    assign at_zero = (o_hi == 4'd0) && (o_lo == 4'd0);
    assign carry   = inc && !dec && at_max;

    always_ff @(posedge i_clk) begin
        if (clear) begin
            o_hi <= 4'd0;
            o_lo <= 4'd0;
        end else if (inc && !dec) begin
            if (at_max) begin
                o_hi <= 4'd0;
                o_lo <= 4'd0;
            end else if (o_lo == 4'd9) begin
                o_hi <= o_hi + 4'd1;
                o_lo <= 4'd0;
            end else begin
                o_lo <= o_lo + 4'd1;
            end
        end else if (dec && !inc) begin
            if (at_zero) begin
                o_hi <= MAX_HI;
                o_lo <= MAX_LO;
            end else if (o_lo == 4'd0) begin
                o_hi <= o_hi - 4'd1;
                o_lo <= 4'd9;
            end else begin
                o_lo <= o_lo - 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-setting controller: 1 Hz prescaler, BCD HH:MM:SS
// carry chain, RUN/SET mode FSM and blink mask for the field being set.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_DIV    = 50000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic       i_clk,
    input  logic       r_rst,
    input  logic       i_key_mode,
    input  logic       i_key_inc,
    input  logic       i_key_dec,
    output logic [3:0] o_hour_h,
    output logic [3:0] o_hour_l,
    output logic [3:0] o_minut_h,
    output logic [3:0] o_minut_l,
    output logic [3:0] o_second_h,
    output logic [3:0] o_second_l,
    output logic [7:0] o_blink_mask,
    output logic [1:0] o_mode,
    output logic       o_sec_tick
);

    localparam int PW = $clog2(SEC_DIV);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SEC_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    mode_t          mode_q, mode_nxt;
    logic [PW-1:0]  presc_q;
    logic [BW-1:0]  blink_cnt_q;
    logic           blink_phase_q;
    logic           run, adj_ok, adj_inc, adj_dec, presc_wrap;
    logic           sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
    logic           sec_carry, min_carry, hour_carry_unused;

    always_ff @(posedge i_clk) begin
        if (r_rst) mode_q <= MODE_RUN;
        else       mode_q <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode_q;
        if (i_key_mode) begin
            case (mode_q)
                MODE_RUN:      mode_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_nxt = MODE_SET_MIN;
                MODE_SET_MIN:  mode_nxt = MODE_SET_SEC;
                default:       mode_nxt = MODE_RUN;
            endcase
        end
    end

    // A mode pulse or an inc+dec collision suppresses any adjustment.
    assign run        = (mode_q == MODE_RUN);
    assign adj_ok     = !run && !i_key_mode && (i_key_inc ^ i_key_dec);
    assign adj_inc    = adj_ok && i_key_inc;
    assign adj_dec    = adj_ok && i_key_dec;
    assign presc_wrap = run && (presc_q == PRESC_LAST);

    assign sec_inc  = presc_wrap || ((mode_q == MODE_SET_SEC) && adj_inc);
    assign sec_dec  = (mode_q == MODE_SET_SEC) && adj_dec;
    assign min_inc  = (run && sec_carry) || ((mode_q == MODE_SET_MIN) && adj_inc);
    assign min_dec  = (mode_q == MODE_SET_MIN) && adj_dec;
    assign hour_inc = (run && min_carry) || ((mode_q == MODE_SET_HOUR) && adj_inc);
    assign hour_dec = (mode_q == MODE_SET_HOUR) && adj_dec;

    always_ff @(posedge i_clk) begin
        if (r_rst) begin
            presc_q    <= '0;
            o_sec_tick <= 1'b0;
        end else begin
            o_sec_tick <= presc_wrap;
            if (!run || presc_wrap) presc_q <= '0;
            else                    presc_q <= presc_q + 1'b1;
        end
    end

    // Restarting on every mode change or accepted edit keeps the field visible while adjusted.
    always_ff @(posedge i_clk) begin
        if (r_rst || run || i_key_mode || adj_ok) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= !blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    assign o_mode       = mode_q;
    assign o_blink_mask = blink_phase_q ? field_mask(mode_q) : 8'h00;

    bcd2_mod_counter #(.MAX(MIN_MAX)) u_sec (
        .i_clk (i_clk),
        .clear (r_rst),
        .inc   (sec_inc),
        .dec   (sec_dec),
        .o_hi  (o_second_h),
        .o_lo  (o_second_l),
        .carry (sec_carry)
    );

    bcd2_mod_counter #(.MAX(MIN_MAX)) u_min (
        .i_clk (i_clk),
        .clear (r_rst),
        .inc   (min_inc),
        .dec   (min_dec),
        .o_hi  (o_minut_h),
        .o_lo  (o_minut_l),
        .carry (min_carry)
    );

    bcd2_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .i_clk (i_clk),
        .clear (r_rst),
        .inc   (hour_inc),
        .dec   (hour_dec),
        .o_hi  (o_hour_h),
        .o_lo  (o_hour_l),
        .carry (hour_carry_unused)
    );

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with a short prescaler and blink period.
module tb_clock_time_ctrl;

    localparam int SEC_DIV    = 10;
    localparam int BLINK_HALF = 4;

    logic       i_clk = 1'b0;
    logic       r_rst;
    logic       i_key_mode, i_key_inc, i_key_dec;
    logic [3:0] o_hour_h, o_hour_l, o_minut_h, o_minut_l, o_second_h, o_second_l;
    logic [7:0] o_blink_mask;
    logic [1:0] o_mode;
    logic       o_sec_tick;

    int checks = 0;
    int fails  = 0;

    clock_time_ctrl #(.SEC_DIV(SEC_DIV), .BLINK_HALF(BLINK_HALF)) dut (
        .i_clk        (i_clk),
        .r_rst        (r_rst),
        .i_key_mode   (i_key_mode),
        .i_key_inc    (i_key_inc),
        .i_key_dec    (i_key_dec),
        .o_hour_h     (o_hour_h),
        .o_hour_l     (o_hour_l),
        .o_minut_h    (o_minut_h),
        .o_minut_l    (o_minut_l),
        .o_second_h   (o_second_h),
        .o_second_l   (o_second_l),
        .o_blink_mask (o_blink_mask),
        .o_mode       (o_mode),
        .o_sec_tick   (o_sec_tick)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] time_now();
        return {8'h00, o_hour_h, o_hour_l, o_minut_h, o_minut_l, o_second_h, o_second_l};
    endfunction

    task automatic step(input logic m, input logic inc, input logic dec);
        i_key_mode = m;
        i_key_inc  = inc;
        i_key_dec  = dec;
        @(posedge i_clk);
        #1;
        i_key_mode = 1'b0;
        i_key_inc  = 1'b0;
        i_key_dec  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        r_rst = 1'b1; i_key_mode = 1'b0; i_key_inc = 1'b0; i_key_dec = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        check("rst_time", time_now(), 32'h000000);
        check("rst_mode", 32'(o_mode), 32'd0);
        check("rst_mask", 32'(o_blink_mask), 32'h00);
        check("rst_tick", 32'(o_sec_tick), 32'd0);
        r_rst = 1'b0;

        // 1: first tick exactly SEC_DIV cycles after reset
        for (int i = 1; i < SEC_DIV; i++) begin
            step(0, 0, 0);
            check("t1_notick", 32'(o_sec_tick), 32'd0);
            check("t1_mask", 32'(o_blink_mask), 32'h00);
        end
        step(0, 0, 0);
        check("t1_tick", 32'(o_sec_tick), 32'd1);
        check("t1_time", time_now(), 32'h000001);
        step(0, 0, 0);
        check("t1_tick_once", 32'(o_sec_tick), 32'd0);

        // 2: set 23:59:59 and roll over to 00:00:00
        step(1, 0, 0);
        check("t2_mode_hour", 32'(o_mode), 32'd1);
        check("t2_time_hold", time_now(), 32'h000001);
        step(0, 0, 1);
        step(1, 0, 0);
        check("t2_mode_min", 32'(o_mode), 32'd2);
        step(0, 0, 1);
        step(1, 0, 0);
        check("t2_mode_sec", 32'(o_mode), 32'd3);
        step(0, 0, 1);
        step(0, 0, 1);
        check("t2_set_time", time_now(), 32'h235959);
        step(1, 0, 0);
        check("t2_mode_run", 32'(o_mode), 32'd0);
        for (int i = 1; i < SEC_DIV; i++) begin
            step(0, 0, 0);
            check("t2_notick", 32'(o_sec_tick), 32'd0);
            check("t2_time_wait", time_now(), 32'h235959);
        end
        step(0, 0, 0);
        check("t2_tick", 32'(o_sec_tick), 32'd1);
        check("t2_rollover", time_now(), 32'h000000);

        // 3: hour increment wraps modulo 24, decrement wraps 00 -> 23
        step(1, 0, 0);
        check("t3_mode", 32'(o_mode), 32'd1);
        for (int i = 1; i <= 24; i++) begin
            step(0, 1, 0);
            if (i == 10) check("t3_hour10", time_now(), 32'h100000);
            if (i == 20) check("t3_hour20", time_now(), 32'h200000);
        end
        check("t3_hour_wrap", time_now(), 32'h000000);
        step(0, 0, 1);
        check("t3_hour_dec", time_now(), 32'h230000);

        // 4: blink in SET_MIN and restart on an accepted inc
        step(1, 0, 0);
        check("t4_mode", 32'(o_mode), 32'd2);
        check("t4_mask_start", 32'(o_blink_mask), 32'h00);
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0);
            check("t4_mask", 32'(o_blink_mask), (i < 4) ? 32'h00 : 32'h18);
        end
        step(0, 1, 0);
        check("t4_mask_inc", 32'(o_blink_mask), 32'h00);
        check("t4_time_inc", time_now(), 32'h230100);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0);
            check("t4_mask_restart", 32'(o_blink_mask), (i < 4) ? 32'h00 : 32'h18);
        end

        // 5: collisions and holding in SET_SEC
        step(0, 1, 1);
        check("t5_incdec", time_now(), 32'h230100);
        check("t5_incdec_mode", 32'(o_mode), 32'd2);
        step(1, 1, 0);
        check("t5_modeinc_mode", 32'(o_mode), 32'd3);
        check("t5_modeinc_time", time_now(), 32'h230100);
        for (int i = 1; i <= 30; i++) begin
            step(0, 0, 0);
            check("t5_hold_notick", 32'(o_sec_tick), 32'd0);
            check("t5_hold_mask", 32'(o_blink_mask), ((i / 4) % 2 == 1) ? 32'h03 : 32'h00);
        end
        check("t5_hold_time", time_now(), 32'h230100);

        // 6: reach 12:34:56 in SET_SEC, then reset mid-operation
        step(1, 0, 0);
        check("t6_mode_run", 32'(o_mode), 32'd0);
        step(1, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1);
        step(1, 0, 0);
        for (int i = 0; i < 33; i++) step(0, 1, 0);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        check("t6_set_time", time_now(), 32'h123456);
        check("t6_set_mode", 32'(o_mode), 32'd3);
        r_rst = 1'b1;
        step(0, 0, 0);
        r_rst = 1'b0;
        check("t6_rst_time", time_now(), 32'h000000);
        check("t6_rst_mode", 32'(o_mode), 32'd0);
        check("t6_rst_mask", 32'(o_blink_mask), 32'h00);
        check("t6_rst_tick", 32'(o_sec_tick), 32'd0);
        for (int i = 1; i < SEC_DIV; i++) begin
            step(0, 0, 0);
            check("t6_notick", 32'(o_sec_tick), 32'd0);
        end
        step(0, 0, 0);
        check("t6_tick", 32'(o_sec_tick), 32'd1);
        check("t6_time", time_now(), 32'h000001);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and time-setting controller for the 8-digit HH-MM-SS seven-segment clock.
- Generates the 1 Hz tick and keeps hours, minutes and seconds as BCD digits.
- Runs a mode FSM so the user can set hours, minutes and seconds with three key pulses.
- Drives the six BCD digit inputs of the display scan controller and a per-digit blink mask that flashes the field being set.

Parameters:
SEC_DIV, 50000000, i_clk cycles per second (prescaler modulus); legal range is 2 or more.
BLINK_HALF, 12500000, i_clk cycles per blink half-period; legal range is 1 or more.

Ports:
i_clk  input  1  system clock
r_rst  input  1  synchronous reset, active-high
i_key_mode  input  1  single-cycle pulse (debounced upstream); advances the mode
i_key_inc  input  1  single-cycle pulse; increments the selected field
i_key_dec  input  1  single-cycle pulse; decrements the selected field
o_hour_h  output  4  hours tens, BCD 0-2
o_hour_l  output  4  hours units, BCD 0-9
o_minut_h  output  4  minutes tens, BCD 0-5
o_minut_l  output  4  minutes units, BCD 0-9
o_second_h  output  4  seconds tens, BCD 0-5
o_second_l  output  4  seconds units, BCD 0-9
o_blink_mask  output  8  1 = blank this digit now; bit0 = second_l, bit1 = second_h, bit2 = separator, bit3 = minut_l, bit4 = minut_h, bit5 = separator, bit6 = hour_l, bit7 = hour_h
o_mode  output  2  current mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
o_sec_tick  output  1  one-cycle pulse on each 1 Hz tick

Behaviour:
- All logic is clocked on rising i_clk. r_rst has priority over everything.
- Reset values:
  - all time digits 0 (00:00:00)
  - o_mode = RUN, o_blink_mask = 0, o_sec_tick = 0
  - prescaler = 0, blink counter = 0, blink phase = 0
- All outputs are registered. A key pulse sampled at edge n shows its effect on the outputs after edge n, i.e. the next cycle.
- Prescaler:
  - In RUN it counts 0..SEC_DIV-1.
  - On the wrap it asserts o_sec_tick for one cycle and the time advances by 1 s in the same edge.
  - In any SET mode the prescaler is held at 0 and there are no ticks.
  - On SET_SEC -> RUN the prescaler restarts at 0, so the first tick arrives SEC_DIV cycles after the transition.
- Carry chain:
  - second_l 9 -> 0 carries into second_h.
  - Seconds 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours.
  - hour_l 9 -> 0 increments hour_h (09 -> 10, 19 -> 20).
  - 23:59:59 -> 00:00:00 with no further carry.
- Mode FSM: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, advancing on each i_key_mode pulse.
- In SET modes:
  - i_key_inc adds 1 to the selected field modulo 24 or 60, with no carry into other fields.
  - i_key_dec subtracts 1; 00 wraps to 23 or 59.
- Simultaneous and ignored events:
  - In RUN, inc and dec are ignored.
  - inc and dec in the same cycle: both ignored.
  - mode together with inc or dec: mode wins and the value is unchanged.
  - A tick in the same cycle as mode from RUN: the tick is applied and the mode still advances.
- Blink:
  - The blink counter runs only in SET modes, counting 0..BLINK_HALF-1 and toggling the phase on wrap.
  - Counter and phase are cleared to 0 on every mode change and on every accepted inc/dec, so the field stays visible while being adjusted.
  - Phase 1 blanks the selected field: bits 7:6 in SET_HOUR, 4:3 in SET_MIN, 1:0 in SET_SEC.
  - Bits 2 and 5 are always 0. In RUN the mask is 0.
- Invariant: the digits are always legal BCD within range.
- Reset mid-operation returns to the reset state on the next edge regardless of mode.

Decomposition:
- Shared package clock_pkg:
  - mode encoding constants MODE_RUN = 0, MODE_SET_HOUR = 1, MODE_SET_MIN = 2, MODE_SET_SEC = 3
  - HOUR_MAX = 23, MIN_MAX = 59
  - digit-position indices for the blink mask
- One sub-module, bcd2_mod_counter:
  - two-digit BCD up/down counter with parameter MAX
  - inputs: inc, dec, clear
  - outputs: carry on MAX -> 0
  - instantiated three times (hours, minutes, seconds)

Test Plan:
1. SEC_DIV=10, BLINK_HALF=4; reset, then 10 cycles -> o_sec_tick pulses once at cycle 10, second_l = 1; all other outputs 0 and mask 0 beforehand.
2. Set 23:59:59 through the SET modes, then mode back to RUN -> after 10 cycles a single tick and the time reads 00:00:00; no tick earlier than 10 cycles after the transition.
3. One mode pulse (o_mode = 1); 24 inc pulses from 00 -> hours back at 00 with minutes/seconds untouched; one dec from 00 -> hour_h = 2, hour_l = 3.
4. In SET_MIN, blink mask alternates 0 for 4 cycles, then 8'b00011000 for 4 cycles; an inc pulse during the blank phase -> mask 0 next cycle and the counter restarts.
5. Simultaneous and hold cases:
   - inc+dec in one cycle -> no change.
   - mode+inc in one cycle -> mode advances, value unchanged.
   - Hold in SET_SEC for 30 cycles -> no o_sec_tick, seconds unchanged.
6. Time 12:34:56 in SET_SEC, assert r_rst for one cycle -> next cycle 00:00:00, o_mode = 0, mask 0, and the first tick arrives 10 cycles after reset deasserts.
